// File: rtl/riscv_pkg.sv
// Shared widths and the fetch-entry record used by the fetch path.
// Modules with non-default widths build a matching entry type locally.
package riscv_pkg;
    localparam int PC_W_DEF    = 12;
    localparam int INSTR_W_DEF = 32;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle seen from the fetch stage.
interface fetch_unit_if
    import riscv_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) ();
    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_en, output imem_addr, input imem_data);
    modport slave  (input imem_en, input imem_addr, output imem_data);
endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries with flush and a combinational head.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && (count_reg != '0);

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (PTR_W+1)'(1);
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - (PTR_W+1)'(1);
            end
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, credit-based issue and redirect flush.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   StallD,
    input  logic                   PCSrcE,
    input  logic [PC_W-1:0]        PCTargetE,
    output logic                   ImemEn,
    output logic [PC_W-1:0]        ImemAddr,
    input  logic [INSTR_W-1:0]     ImemData,
    output logic [INSTR_W-1:0]     InstrD,
    output logic [PC_W-1:0]        PCD,
    output logic [PC_W-1:0]        PCPlus4D,
    output logic                   ValidD,
    output logic [$clog2(DEPTH):0] FetchCount
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]  pcf_reg;
    logic [PC_W-1:0]  issue_pc_reg;
    logic             inflight_reg;
    logic [CNT_W-1:0] count;
    logic             issue;
    logic             push;
    logic             pop;
    entry_t           push_data;
    entry_t           head;

    // A fetch is only issued when its response is guaranteed a free slot.
    assign issue = !PCSrcE && ((count + CNT_W'(inflight_reg)) < CNT_W'(DEPTH));
    assign push  = inflight_reg && !PCSrcE;
    assign pop   = ValidD && !StallD && !PCSrcE;

    assign push_data = '{pc: issue_pc_reg, instr: ImemData};

    always_ff @(posedge clock) begin
        if (reset) begin
            pcf_reg      <= RESET_PC;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (PCSrcE) begin
                pcf_reg <= PCTargetE;
            end else if (issue) begin
                pcf_reg <= pcf_reg + PC_W'(4);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (issue) begin
            issue_pc_reg <= pcf_reg;
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .clear     (PCSrcE),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign ImemEn     = issue;
    assign ImemAddr   = pcf_reg;
    assign InstrD     = head.instr;
    assign PCD        = head.pc;
    assign PCPlus4D   = head.pc + PC_W'(4);
    assign ValidD     = (count != '0);
    assign FetchCount = count;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed sequences.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        StallD;
    logic        PCSrcE;
    logic [11:0] PCTargetE;

    logic [31:0] InstrD, InstrD2;
    logic [11:0] PCD, PCD2, PCPlus4D, PCPlus4D2;
    logic        ValidD, ValidD2;
    logic [2:0]  FetchCount, FetchCount2;

    fetch_unit_if #(.PC_W(12), .INSTR_W(32)) bus  ();
    fetch_unit_if #(.PC_W(12), .INSTR_W(32)) bus2 ();

    fetch_unit #(.PC_W(12), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(12'h000)) dut (
        .clock(clock), .reset(reset), .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ImemEn(bus.imem_en), .ImemAddr(bus.imem_addr), .ImemData(bus.imem_data),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchCount(FetchCount)
    );

    fetch_unit #(.PC_W(12), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(12'hFFC)) dut2 (
        .clock(clock), .reset(reset), .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ImemEn(bus2.imem_en), .ImemAddr(bus2.imem_addr), .ImemData(bus2.imem_data),
        .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2), .ValidD(ValidD2), .FetchCount(FetchCount2)
    );

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {16'hC0DE, 4'h0, a};
    endfunction

    // Memory models: registered read, data valid the cycle after the strobe.
    always @(posedge clock) begin
        if (bus.imem_en) bus.imem_data <= mem_word(bus.imem_addr);
        if (bus2.imem_en) bus2.imem_data <= mem_word(bus2.imem_addr);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [11:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        mq[$];
    exp_t        m_pend;
    logic [11:0] m_pcf;
    logic        m_infl;
    logic        m_live = 1'b0;

    // One clock cycle: drive inputs after the falling edge, compare, advance model.
    task automatic step(input logic r, input logic s, input logic p, input logic [11:0] t);
        logic en_m;
        @(negedge clock);
        reset = r; StallD = s; PCSrcE = p; PCTargetE = t;
        #1;
        en_m = !p && ((mq.size() + int'(m_infl)) < DEPTH);
        if (m_live) begin
            check("ImemEn", 32'(bus.imem_en), 32'(en_m));
            check("ImemAddr", 32'(bus.imem_addr), 32'(m_pcf));
            check("ValidD", 32'(ValidD), 32'(mq.size() != 0));
            check("FetchCount", 32'(FetchCount), 32'(mq.size()));
            if (mq.size() != 0) begin
                check("PCD", 32'(PCD), 32'(mq[0].pc));
                check("PCPlus4D", 32'(PCPlus4D), 32'(12'(mq[0].pc + 12'd4)));
                check("InstrD", InstrD, mq[0].instr);
            end
        end
        if (r) begin
            m_pcf = 12'h000; m_infl = 1'b0; mq.delete(); m_live = 1'b1;
        end else if (m_live) begin
            if (p) mq.delete();
            else begin
                if (mq.size() != 0 && !s) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_pend);
            end
            if (en_m) m_pend = '{pc: m_pcf, instr: mem_word(m_pcf)};
            m_infl = en_m;
            m_pcf  = p ? t : (en_m ? 12'(m_pcf + 12'd4) : m_pcf);
        end
    endtask

    typedef struct {
        logic        rst, stall, pcsrc;
        logic [11:0] tgt;
        logic        chk, en;
        logic [11:0] addr;
        logic        valid;
        logic [11:0] pcd;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic reached;
        reset = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;

        // Free run, then redirect to 0x100 in cycle 5.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 3'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b0, 12'h000, 3'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h004, 1'b0, 12'h000, 3'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h008, 1'b1, 12'h000, 3'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h00C, 1'b1, 12'h004, 3'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 12'h100, 1'b1, 1'b0, 12'h010, 1'b1, 12'h008, 3'd1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h100, 1'b0, 12'h000, 3'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h104, 1'b0, 12'h000, 3'd0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h108, 1'b1, 12'h100, 3'd1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h10C, 1'b1, 12'h104, 3'd1};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].stall, tbl[i].pcsrc, tbl[i].tgt);
            if (tbl[i].chk) begin
                check("tbl_en", 32'(bus.imem_en), 32'(tbl[i].en));
                check("tbl_addr", 32'(bus.imem_addr), 32'(tbl[i].addr));
                check("tbl_valid", 32'(ValidD), 32'(tbl[i].valid));
                check("tbl_count", 32'(FetchCount), 32'(tbl[i].cnt));
                if (tbl[i].valid) begin
                    check("tbl_pcd", 32'(PCD), 32'(tbl[i].pcd));
                    check("tbl_plus4", 32'(PCPlus4D), 32'(12'(tbl[i].pcd + 12'd4)));
                end
            end
            // Second instance starts at 0xFFC and must wrap to 0x000.
            if (i == 1) check("wrap_addr0", 32'(bus2.imem_addr), 32'h0FFC);
            if (i == 2) check("wrap_addr1", 32'(bus2.imem_addr), 32'h0000);
            if (i == 3) begin
                check("wrap_pcd0", 32'(PCD2), 32'h0FFC);
                check("wrap_plus4", 32'(PCPlus4D2), 32'h0000);
            end
            if (i == 4) check("wrap_pcd1", 32'(PCD2), 32'h0000);
        end

        // Stall until full, then drain with no gaps or duplicates.
        step(1'b1, 1'b0, 1'b0, 12'h0);
        reached = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 1'b0, 12'h0);
            if (FetchCount == 3'd4) begin reached = 1'b1; break; end
        end
        check("stall_full", 32'(reached), 32'h1);
        check("stall_en_off", 32'(bus.imem_en), 32'h0);
        step(1'b0, 1'b1, 1'b0, 12'h0);
        check("stall_hold", 32'(FetchCount), 32'h4);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 12'h0);
            check("drain_valid", 32'(ValidD), 32'h1);
            check("drain_pcd", 32'(PCD), 32'(k * 4));
        end

        // Redirect while full and stalled.
        step(1'b1, 1'b0, 1'b0, 12'h0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 12'h0);
        check("flush_pre_full", 32'(FetchCount), 32'h4);
        step(1'b0, 1'b1, 1'b1, 12'h040);
        step(1'b0, 1'b0, 1'b0, 12'h0);
        check("flush_count", 32'(FetchCount), 32'h0);
        reached = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (ValidD) begin reached = 1'b1; break; end
            step(1'b0, 1'b0, 1'b0, 12'h0);
        end
        check("flush_seen", 32'(reached), 32'h1);
        check("flush_pcd", 32'(PCD), 32'h040);

        // Reset with three entries queued and a fetch in flight.
        step(1'b1, 1'b0, 1'b0, 12'h0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 12'h0);
        check("mid_count", 32'(FetchCount), 32'h3);
        step(1'b1, 1'b1, 1'b1, 12'h200);
        step(1'b0, 1'b0, 1'b0, 12'h0);
        check("rst_valid", 32'(ValidD), 32'h0);
        check("rst_count", 32'(FetchCount), 32'h0);
        check("rst_addr", 32'(bus.imem_addr), 32'h000);
        reached = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b0, 12'h0);
            if (ValidD) begin reached = 1'b1; break; end
        end
        check("rst_seen", 32'(reached), 32'h1);
        check("rst_pcd", 32'(PCD), 32'h000);
        check("rst_instr", InstrD, mem_word(12'h000));
        step(1'b0, 1'b0, 1'b0, 12'h0);
        check("rst_pcd_next", 32'(PCD), 32'h004);

        // Random traffic against the reference model.
        for (int k = 0; k < 300; k++) begin
            logic [11:0] t;
            t = {$urandom_range(0, 1023), 2'b00};
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 15) == 0), t);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
